// File: rtl/gen_toggle_cover_collector.sv
// gen_toggle_cover_collector: sticky per-bit rise/fall toggle coverage with live count and valid/ready snapshot dump
module gen_toggle_cover_collector #(
    parameter int WIDTH       = 8,
    parameter int COVER_INDEX = 0,
    parameter int IDX_W       = 32,
    parameter int CNT_W       = $clog2(2 * WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] signal,
    input  logic             clear,
    input  logic             dump_req,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [IDX_W-1:0] dump_index,
    output logic             dump_rise,
    output logic             dump_fall,
    output logic             dump_done,
    output logic             dump_busy,
    output logic [CNT_W-1:0] covered_count
);
    localparam int PW = WIDTH > 1 ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] prev_q, rise_hit, fall_hit, rise_nxt, fall_nxt, snap_rise, snap_fall;
    logic             base_valid;
    logic [PW-1:0]    ptr;

    // next hit values are shared so a dump snapshot includes hits landing on the same edge
    always_comb begin
        rise_nxt = clear ? '0 : (enable && base_valid) ? rise_hit | (~prev_q & signal) : rise_hit;
        fall_nxt = clear ? '0 : (enable && base_valid) ? fall_hit | (prev_q & ~signal) : fall_hit;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q        <= '0;
            base_valid    <= 1'b0;
            rise_hit      <= '0;
            fall_hit      <= '0;
            covered_count <= '0;
        end else begin
            prev_q        <= enable ? signal : prev_q;
            base_valid    <= enable && !clear;
            rise_hit      <= rise_nxt;
            fall_hit      <= fall_nxt;
            covered_count <= CNT_W'($countones({rise_hit, fall_hit}));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            snap_rise  <= '0;
            snap_fall  <= '0;
            dump_valid <= 1'b0;
            dump_done  <= 1'b0;
            dump_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (dump_req) begin
                    snap_rise  <= rise_nxt;
                    snap_fall  <= fall_nxt;
                    ptr        <= '0;
                    state      <= SEND;
                    dump_valid <= 1'b1;
                    dump_busy  <= 1'b1;
                end
                SEND: if (dump_ready) begin
                    if (ptr == PW'(WIDTH - 1)) begin
                        state      <= DONE;
                        dump_valid <= 1'b0;
                        dump_done  <= 1'b1;
                    end else begin
                        ptr <= ptr + PW'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    dump_done <= 1'b0;
                    dump_busy <= 1'b0;
                end
            endcase
        end
    end

    assign dump_index = dump_valid ? IDX_W'(COVER_INDEX) + IDX_W'(ptr) : '0;
    assign dump_rise  = dump_valid & snap_rise[ptr];
    assign dump_fall  = dump_valid & snap_fall[ptr];
endmodule

// File: tb/tb_gen_toggle_cover_collector.sv
// tb_gen_toggle_cover_collector: directed and random checks against a bit-level coverage model
module tb_gen_toggle_cover_collector;
    localparam int W  = 8;
    localparam int CI = 100;

    logic         clock = 0, reset = 0, enable = 0, clear = 0, dump_req = 0, dump_ready = 0;
    logic [W-1:0] signal = '0;
    logic         dump_valid, dump_rise, dump_fall, dump_done, dump_busy;
    logic [31:0]  dump_index;
    logic [4:0]   covered_count;

    int checks = 0, errors = 0;

    bit [W-1:0] m_prev, m_rise, m_fall, snap_r, snap_f;
    bit         m_base;
    int         m_cnt;

    gen_toggle_cover_collector #(.WIDTH(W), .COVER_INDEX(CI)) dut (
        .clock(clock), .reset(reset), .enable(enable), .signal(signal), .clear(clear),
        .dump_req(dump_req), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_index(dump_index), .dump_rise(dump_rise), .dump_fall(dump_fall),
        .dump_done(dump_done), .dump_busy(dump_busy), .covered_count(covered_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // count is what the hit map held one edge ago; hits follow the toggle rules bit by bit
    task automatic model_edge();
        int c = 0;
        for (int i = 0; i < W; i++) c += int'(m_rise[i]) + int'(m_fall[i]);
        if (reset) begin
            m_prev = '0; m_rise = '0; m_fall = '0; m_base = 0; m_cnt = 0;
            return;
        end
        m_cnt = c;
        if (clear) begin
            m_rise = '0; m_fall = '0; m_base = 0;
        end else if (enable) begin
            if (m_base)
                for (int i = 0; i < W; i++) begin
                    if (!m_prev[i] && signal[i]) m_rise[i] = 1;
                    if (m_prev[i] && !signal[i]) m_fall[i] = 1;
                end
            m_prev = signal;
            m_base = 1;
        end else begin
            m_base = 0;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        check("covered_count", covered_count, m_cnt);
    endtask

    // mode 0: ready held high, 1: alternating, 2: random ready and random signal
    task automatic do_dump(input int mode, input bit clr, input bit req_mid);
        int k = 0, cyc = 0;
        dump_req = 1;
        step();
        dump_req = 0;
        snap_r = m_rise;
        snap_f = m_fall;
        check("busy_after_req", dump_busy, 1);
        while (k < W && cyc < 200) begin
            check("dump_valid", dump_valid, 1);
            check("dump_index", dump_index, CI + k);
            check("dump_rise", dump_rise, snap_r[k]);
            check("dump_fall", dump_fall, snap_f[k]);
            check("dump_done_early", dump_done, 0);
            dump_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom);
            clear = clr && cyc == 0;
            dump_req = req_mid && k == 3;
            if (mode == 2) signal = W'($urandom);
            step();
            clear = 0;
            dump_req = 0;
            if (dump_ready) k++;
            cyc++;
        end
        check("dump_records", k, W);
        dump_ready = 0;
        check("done_pulse", dump_done, 1);
        check("valid_in_done", dump_valid, 0);
        check("busy_in_done", dump_busy, 1);
        step();
        check("done_single", dump_done, 0);
        check("busy_idle", dump_busy, 0);
        check("valid_idle", dump_valid, 0);
    endtask

    initial begin
        reset = 1;
        step();
        check("rst_valid", dump_valid, 0);
        check("rst_done", dump_done, 0);
        check("rst_busy", dump_busy, 0);
        check("rst_index", dump_index, 0);
        check("rst_rise", dump_rise, 0);
        check("rst_fall", dump_fall, 0);
        reset = 0;

        enable = 1; signal = 8'h00;
        step(); step();
        signal = 8'h05; step();
        signal = 8'h00; step();
        step();
        check("pulse_count4", covered_count, 4);

        reset = 1; step(); reset = 0;
        signal = 8'hFF; step();
        check("baseline_nohits", covered_count, 0);
        step();
        check("baseline_nohits2", covered_count, 0);
        signal = 8'h00; step(); step();
        check("fall_all_count8", covered_count, 8);

        enable = 0; signal = 8'h08; step(); step();
        enable = 1; step(); step(); step();
        check("gap_no_rise", covered_count, 8);

        reset = 1; step(); reset = 0;
        enable = 1; signal = 8'h02; step();
        signal = 8'h81; step(); step();
        check("pre_dump_count3", covered_count, 3);
        do_dump(1, 0, 0);

        do_dump(0, 1, 1);
        step();
        check("post_clear_count0", covered_count, 0);

        signal = 8'h00; step();
        signal = 8'hF0; step(); step();
        dump_req = 1; step(); dump_req = 0;
        dump_ready = 1;
        step(); step(); step();
        check("mid_dump_index", dump_index, CI + 3);
        reset = 1; dump_ready = 0; step(); reset = 0;
        check("rst_mid_valid", dump_valid, 0);
        check("rst_mid_busy", dump_busy, 0);
        check("rst_mid_done", dump_done, 0);
        check("rst_mid_count", covered_count, 0);
        step();
        check("rst_mid_no_done", dump_done, 0);

        for (int n = 0; n < 300; n++) begin
            enable = ($urandom % 8) != 0;
            signal = W'($urandom);
            clear = ($urandom % 40) == 0;
            step();
            clear = 0;
            if (n % 70 == 35) do_dump(2, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gen_toggle_cover_collector.md
Name: gen_toggle_cover_collector

Overview:
- Parametrised, synthesizable toggle-coverage collector for WIDTH-bit monitored signals.
- Per bit, records sticky rise (0->1) and fall (1->0) hits.
- Keeps a running count of covered points.
- Unloads a snapshot of the hit bitmap over a valid/ready stream, one record per bit, tagged with the global cover index. Used in FPGA/emulation builds where DPI callbacks are unavailable.

Parameters:
- WIDTH, 8, number of monitored bits (1..1024).
- COVER_INDEX, 0, global cover index of bit 0; bit i reports COVER_INDEX+i.
- IDX_W, 32, width of the dump_index field.
- CNT_W, $clog2(2*WIDTH+1), width of covered_count.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  sampling enable.
- signal  in  WIDTH  monitored vector.
- clear  in  1  one-cycle request to clear live hits and baseline.
- dump_req  in  1  one-cycle request to start a dump.
- dump_valid  out  1  dump record valid.
- dump_ready  in  1  consumer accepts record.
- dump_index  out  IDX_W  COVER_INDEX + bit number.
- dump_rise  out  1  snapshot rise hit for that bit.
- dump_fall  out  1  snapshot fall hit for that bit.
- dump_done  out  1  one-cycle pulse after last record accepted.
- dump_busy  out  1  high while the dump FSM is not IDLE.
- covered_count  out  CNT_W  popcount of live rise_hit|fall_hit points (0..2*WIDTH).

Behaviour:
- Reset (reset=1 at an edge):
  - Clears prev_q, base_valid, rise_hit, fall_hit, snapshot, covered_count, FSM=IDLE, bit pointer=0.
  - All outputs read 0.
  - Reset dominates every other input, including mid-dump; no dump_done pulse.
- Sampling, at each edge with enable=1:
  - prev_q <= signal; base_valid <= 1.
  - If base_valid was already 1: rise_hit[i] |= ~prev_q[i] & signal[i]; fall_hit[i] |= prev_q[i] & ~signal[i].
  - Net effect: the first enabled edge only establishes the baseline and never sets hits.
  - A hit appears in rise_hit/fall_hit at the edge where the changed value is first sampled.
- enable=0 at an edge: base_valid <= 0, hits held. Re-enabling therefore re-baselines, so no false toggle is recorded across a disabled gap.
- Hits are sticky until clear or reset.
- clear=1 at an edge: rise_hit, fall_hit and base_valid <= 0.
  - Clear wins over a toggle detected in the same cycle.
  - covered_count reaches 0 one cycle later.
- covered_count is a registered popcount of {rise_hit, fall_hit}, lagging hit registers by one cycle. No overflow is possible.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE:
    - dump_req=1 -> copy live rise_hit/fall_hit into the snapshot at this edge (includes hits set at this same edge), pointer=0, go to SEND.
    - dump_busy is asserted from the next cycle.
  - SEND:
    - dump_valid=1; dump_index=COVER_INDEX+pointer (zero-extended/truncated to IDX_W); dump_rise/dump_fall from the snapshot at pointer.
    - Outputs stay stable while dump_ready=0.
    - On valid&ready: if pointer==WIDTH-1, go to DONE; else pointer+1.
    - No bubble between records when ready is held high: WIDTH records in WIDTH cycles.
  - DONE: dump_done=1 for exactly one cycle, dump_valid=0, then IDLE.
  - dump_req outside IDLE is ignored (not queued).
- Sampling, clear and covered_count run independently of the dump. clear during SEND does not alter the snapshot, so the dump completes with pre-clear data.
- WIDTH=1: SEND lasts one handshake; the pointer is a 1-bit register that stays 0.
- Latency, dump_req to first dump_valid: 1 cycle. Latency, last handshake to dump_done: 1 cycle.

Test Plan:
- Reset, enable=1, signal=0x00 for 2 cycles, then 0x05, then 0x00 -> rise_hit=0x05, fall_hit=0x05, covered_count=4 one cycle after the fall hits set.
- Baseline: reset, enable=1 with signal=0xFF on the first enabled edge -> no hits. Then signal 0x00 -> fall_hit=0xFF, rise_hit=0x00, covered_count=8.
- Gap: toggle bit3 0->1 while enable=0, then re-enable -> no rise recorded for bit3; covered_count unchanged.
- Dump with COVER_INDEX=100, rise=0x81, fall=0x02, dump_ready alternating 1/0:
  - 8 records, indices 100..107.
  - Record 100 rise=1, record 101 fall=1, record 107 rise=1, others 0.
  - Outputs stable during stalls; dump_done pulses once.
- clear asserted on the cycle after dump_req, plus a second dump_req mid-dump -> dump still reports pre-clear bitmap; covered_count=0; second request ignored; only one dump_done.
- reset asserted during SEND at pointer=3 -> dump_valid=0, dump_busy=0, covered_count=0 next cycle; no dump_done.
